// File: rtl/da_spi_rdbk.sv
// Readback capture for the DAC SPI configuration link: deserializes CS-framed
// traffic, decodes read frames and reports read data, compare result and framing errors.
module da_spi_rdbk #(
    parameter int INSTR_BITS  = 8,
    parameter int DATA_BITS   = 8,
    parameter int SAMPLE_RISE = 1
) (
    input  logic                  GCLK,
    input  logic                  Cir_reset,
    input  logic                  DA_CS,
    input  logic                  DA_SCLK,
    input  logic                  DA_SPI_IN,
    input  logic [DATA_BITS-1:0]  EXP_DATA,
    input  logic                  EXP_EN,
    output logic [INSTR_BITS-2:0] RD_ADDR,
    output logic [DATA_BITS-1:0]  RD_DATA,
    output logic                  RD_VALID,
    output logic                  RD_MATCH,
    output logic                  FRAME_ERR,
    output logic [7:0]            ERR_CNT,
    output logic [15:0]           FRAME_CNT,
    output logic                  BUSY
);

    localparam int FRAME_BITS = INSTR_BITS + DATA_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] INSTR_LAST = CNT_W'(INSTR_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LEN  = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INSTR,
        ST_DATA,
        ST_FULL
    } state_t;

    state_t state, state_n;

    logic cs_meta, cs_sync, cs_prev;
    logic sclk_meta, sclk_sync, sclk_prev;
    logic sdo_meta, sdo_sync;

    logic [FRAME_BITS-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  rw_bit;
    logic                  overrun;

    logic frame_start, do_shift, latch_rw, set_ovr, eof;

    // CS idles high in the synchronizer so reset release never looks like a frame start.
    always_ff @(posedge GCLK or negedge Cir_reset) begin
        if (!Cir_reset) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            sdo_meta  <= 1'b0;
            sdo_sync  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value,
            // which is what turns this chain into a real synchronizer.
            cs_meta   <= DA_CS;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            sclk_meta <= DA_SCLK;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            sdo_meta  <= DA_SPI_IN;
            sdo_sync  <= sdo_meta;
        end
    end

    logic cs_fall, cs_rise, sclk_rise, sclk_fall, sample_edge;
    assign cs_fall     = cs_prev & ~cs_sync;
    assign cs_rise     = ~cs_prev & cs_sync;
    assign sclk_rise   = ~sclk_prev & sclk_sync;
    assign sclk_fall   = sclk_prev & ~sclk_sync;
    assign sample_edge = (SAMPLE_RISE != 0) ? sclk_rise : sclk_fall;

    logic [FRAME_BITS-1:0] shift_next;
    assign shift_next = {shreg[FRAME_BITS-2:0], sdo_sync};

    always_ff @(posedge GCLK or negedge Cir_reset) begin
        if (!Cir_reset) state <= ST_IDLE;
        else            state <= state_n;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_n     = state;
        frame_start = 1'b0;
        do_shift    = 1'b0;
        latch_rw    = 1'b0;
        set_ovr     = 1'b0;
        eof         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    frame_start = 1'b1;
                    state_n     = ST_INSTR;
                end
            end
            ST_INSTR: begin
                if (cs_rise) begin
                    eof     = 1'b1;
                    state_n = ST_IDLE;
                end else if (sample_edge && !cs_sync) begin
                    do_shift = 1'b1;
                    if (bit_cnt == INSTR_LAST) begin
                        latch_rw = 1'b1;
                        state_n  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    eof     = 1'b1;
                    state_n = ST_IDLE;
                end else if (sample_edge && !cs_sync) begin
                    do_shift = 1'b1;
                    if (bit_cnt == FRAME_LAST) state_n = ST_FULL;
                end
            end
            ST_FULL: begin
                if (cs_rise) begin
                    eof     = 1'b1;
                    state_n = ST_IDLE;
                end else if (sample_edge && !cs_sync) begin
                    set_ovr = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge GCLK or negedge Cir_reset) begin
        if (!Cir_reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            rw_bit  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (frame_start) begin
                shreg   <= '0;
                bit_cnt <= '0;
                rw_bit  <= 1'b0;
                overrun <= 1'b0;
            end
            if (do_shift) begin
                shreg   <= shift_next;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (latch_rw) rw_bit  <= shift_next[INSTR_BITS-1];
            if (set_ovr)  overrun <= 1'b1;
        end
    end

    logic frame_bad, data_match, err_inc;
    assign frame_bad  = (bit_cnt != FRAME_LEN) || overrun;
    assign data_match = !EXP_EN || (shreg[DATA_BITS-1:0] == EXP_DATA);
    // A bad frame never reaches the compare, so at most one error count per frame.
    assign err_inc    = eof && (frame_bad || (rw_bit && !data_match));

    always_ff @(posedge GCLK or negedge Cir_reset) begin
        if (!Cir_reset) begin
            RD_ADDR   <= '0;
            RD_DATA   <= '0;
            RD_VALID  <= 1'b0;
            RD_MATCH  <= 1'b1;
            FRAME_ERR <= 1'b0;
            ERR_CNT   <= '0;
            FRAME_CNT <= '0;
        end else begin
            RD_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
            if (eof) begin
                FRAME_CNT <= FRAME_CNT + 16'd1;
                if (frame_bad) begin
                    FRAME_ERR <= 1'b1;
                end else if (rw_bit) begin
                    RD_ADDR  <= shreg[FRAME_BITS-2:DATA_BITS];
                    RD_DATA  <= shreg[DATA_BITS-1:0];
                    RD_VALID <= 1'b1;
                    RD_MATCH <= data_match;
                end
            end
            if (err_inc && (ERR_CNT != 8'hFF)) ERR_CNT <= ERR_CNT + 8'd1;
        end
    end

    assign BUSY = (state != ST_IDLE);

endmodule
